// File: rtl/spi_arbiter.sv
// Round-robin scheduler sharing one SPI master among NREQ byte-transfer requesters.
// Arbitrates in IDLE, drives the master, waits a fixed shift time, returns the received byte.
module spi_arbiter #(
   parameter int NREQ        = 3,
   parameter int XFER_CYCLES = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*8-1:0] req_data,
   input  logic [NREQ*2-1:0] req_slave,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic [7:0]        rsp_data,
   output logic              busy,
   output logic              start,
   output logic [1:0]        slaveSelect,
   output logic [7:0]        masterDataToSend,
   input  logic [7:0]        masterDataReceived
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_XFER, S_ERR, S_DONE} state_t;

   state_t          state_q;
   logic [PW-1:0]   ptr_q, win_q, win_d;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] gnt_q, done_q;
   logic            err_q, busy_q, start_q;
   logic [7:0]      rsp_q, mdts_q;
   logic [1:0]      ss_q;
   logic            win_vld_d;
   logic [1:0]      slave_d;
   logic [7:0]      data_d;
   int              idx;

   // Scan from the farthest position back toward ptr so the nearest set bit wins last.
   always_comb begin
      win_vld_d = 1'b0;
      win_d     = '0;
      idx       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (req[idx]) begin
            win_vld_d = 1'b1;
            win_d     = PW'(idx);
         end
      end
   end

   assign slave_d = req_slave[{win_d, 1'b0} +: 2];
   assign data_d  = req_data[{win_d, 3'b000} +: 8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         rsp_q   <= '0;
         mdts_q  <= '0;
         ss_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (win_vld_d) begin
               win_q  <= win_d;
               gnt_q  <= ONE << win_d;
               busy_q <= 1'b1;
               if (slave_d == 2'd3) begin
                  state_q <= S_ERR;
               end else begin
                  ss_q    <= slave_d;
                  mdts_q  <= data_d;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               start_q <= 1'b1;
               state_q <= S_START;
            end
            S_START: begin
               start_q <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_XFER;
            end
            S_XFER: begin
               if (cnt_q == CW'(XFER_CYCLES - 1)) begin
                  rsp_q   <= masterDataReceived;
                  done_q  <= gnt_q;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Rejected request: master untouched, report the error one cycle after grant.
            S_ERR: begin
               rsp_q   <= '0;
               done_q  <= gnt_q;
               err_q   <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= '0;
               err_q   <= 1'b0;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               ptr_q   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt              = gnt_q;
   assign done             = done_q;
   assign err              = err_q;
   assign rsp_data         = rsp_q;
   assign busy             = busy_q;
   assign start            = start_q;
   assign slaveSelect      = ss_q;
   assign masterDataToSend = mdts_q;
endmodule
